// File: rtl/keypad_scanner_if.sv
// Keypad matrix bundle: row sense in, column drive and decoded key strobes out.
// Latency: none, wiring only.
// Backpressure: none; strobes are single-clock events with no acknowledge.
interface keypad_scanner_if;
    logic [3:0] rows_n;
    logic [2:0] cols_n;
    logic [9:0] keypad;
    logic       start_n;
    logic       stop_n;
    logic [3:0] last_key;

    // Scanner side: senses rows, drives columns and strobes.
    modport master (
        input  rows_n,
        output cols_n, keypad, start_n, stop_n, last_key
    );

    // Keypad/consumer side.
    modport slave (
        output rows_n,
        input  cols_n, keypad, start_n, stop_n, last_key
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: column scan, 2-flop row sync, debounce FSM, one-clock key strobes.
// Latency: strobe lands 1 clock after the DEBOUNCE-th consecutive matching full scan.
// Backpressure: none; consumer must take each strobe in the clock it is presented.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic             clock_i,
    input  logic             clearn_i,
    keypad_scanner_if.master bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_ACCEPT,
        S_PRESSED,
        S_RELEASE
    } state_t;

    // Row (r) / column (c) position to key code: r0..r2 digits 1-9, r3 = '*','0','#'.
    function automatic logic [3:0] key_code(input int r, input int c);
        if (r < 3)       return 4'(r * 3 + c + 1);
        else if (c == 0) return 4'd10;
        else if (c == 1) return 4'd0;
        else             return 4'd11;
    endfunction

    logic [3:0]    rows_s1_q, rows_s2_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [7:0]    snap_q, snap_d;
    logic          sample_now, scan_done;
    logic [11:0]   scan_keys;
    logic [3:0]    n_keys, found_code;
    logic          is_none, is_single;

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    last_q, last_d;
    logic [9:0]    keypad_q, keypad_d;
    logic          start_n_q, start_n_d;
    logic          stop_n_q, stop_n_d;

    // Column dwell timing and snapshot of columns 0 and 1; column 2 is classified live.
    always_comb begin
        sample_now = (dwell_q == DWELL_LAST);
        scan_done  = sample_now && (col_q == 2'd2);
        dwell_d    = sample_now ? '0 : dwell_q + DW'(1);
        col_d      = col_q;
        snap_d     = snap_q;
        if (sample_now) begin
            col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
            if (col_q == 2'd0) snap_d[3:0] = ~rows_s2_q;
            if (col_q == 2'd1) snap_d[7:4] = ~rows_s2_q;
        end
    end

    // Row synchroniser, scan counters and snapshot registers.
    always_ff @(posedge clock_i) begin
        if (!clearn_i) begin
            rows_s1_q <= 4'hF;
            rows_s2_q <= 4'hF;
            dwell_q   <= '0;
            col_q     <= 2'd0;
            snap_q    <= '0;
        end else begin
            rows_s1_q <= bus.rows_n;
            rows_s2_q <= rows_s1_q;
            dwell_q   <= dwell_d;
            col_q     <= col_d;
            snap_q    <= snap_d;
        end
    end

    // Classify the completed scan (bit index = col*4 + row) as none / single / multi.
    always_comb begin
        scan_keys  = {~rows_s2_q, snap_q};
        n_keys     = '0;
        found_code = '0;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (scan_keys[c*4 + r]) begin
                    n_keys     = n_keys + 4'd1;
                    found_code = key_code(r, c);
                end
            end
        end
        is_none   = (n_keys == 4'd0);
        is_single = (n_keys == 4'd1);
    end

    // FSM state register plus registered strobes and last key.
    always_ff @(posedge clock_i) begin
        if (!clearn_i) begin
            state_q   <= S_IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            last_q    <= '0;
            keypad_q  <= '0;
            start_n_q <= 1'b1;
            stop_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            keypad_q  <= keypad_d;
            start_n_q <= start_n_d;
            stop_n_q  <= stop_n_d;
        end
    end

    // Debounce next-state: decisions only on scan_done, except ACCEPT which lasts one clock.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CW'(1);
        case (state_q)
            S_IDLE: begin
                if (scan_done && is_single) begin
                    cand_d  = found_code;
                    cnt_d   = CW'(1);
                    state_d = (DEBOUNCE == 1) ? S_ACCEPT : S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (scan_done) begin
                    if (is_single && found_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_TARGET) state_d = S_ACCEPT;
                    end else if (is_single) begin
                        cand_d = found_code;
                        cnt_d  = CW'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ACCEPT: state_d = S_PRESSED;
            S_PRESSED: begin
                if (scan_done && is_none) begin
                    cnt_d   = CW'(1);
                    state_d = (DEBOUNCE == 1) ? S_IDLE : S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (scan_done) begin
                    if (is_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_TARGET) state_d = S_IDLE;
                    end else begin
                        state_d = S_PRESSED;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe decode for the clock spent in ACCEPT; last key updates alongside it.
    always_comb begin
        keypad_d  = '0;
        start_n_d = 1'b1;
        stop_n_d  = 1'b1;
        last_d    = last_q;
        if (state_d == S_ACCEPT) begin
            last_d = cand_d;
            if (cand_d == 4'd11)      start_n_d = 1'b0;
            else if (cand_d == 4'd10) stop_n_d  = 1'b0;
            else                      keypad_d  = 10'b1 << cand_d;
        end
    end

    assign bus.cols_n   = ~(3'b001 << col_q);
    assign bus.keypad   = keypad_q;
    assign bus.start_n  = start_n_q;
    assign bus.stop_n   = stop_n_q;
    assign bus.last_key = last_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (one full scan = 12 clocks).
// Key changes are applied at scan boundaries; every clock's outputs are compared.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 2;
    localparam int SCAN_CLKS = 3 * SD;

    typedef struct {
        logic [11:0] keys;
        int          exp_code;
    } vec_t;

    // Keypad matrix: position r*3+c holds this key code.
    localparam int KEY_AT [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    logic        clock = 1'b0;
    logic        clearn = 1'b0;
    logic [11:0] keys = '0;
    logic [3:0]  rows;

    int n_vec = 0;
    int n_bad = 0;
    int exp_last = 0;

    // Reference model state: recent scan classes, armed flag, run of empty scans.
    int win[$];
    bit armed = 1'b1;
    int none_run = 0;

    keypad_scanner_if bus();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clock_i (clock),
        .clearn_i(clearn),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Physical matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 3; c++)
            if (bus.cols_n[c] == 1'b0)
                for (int r = 0; r < 4; r++)
                    if (keys[KEY_AT[r*3 + c]]) rows[r] = 1'b0;
    end
    assign bus.rows_n = rows;

    function automatic logic [11:0] K(input int n);
        logic [11:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // -1 = no key, -2 = several keys, else the single key's code.
    function automatic int classify(input logic [11:0] k);
        int code;
        code = -1;
        if ($countones(k) > 1) return -2;
        for (int i = 0; i < 12; i++) if (k[i]) code = i;
        return code;
    endfunction

    // A key is accepted once DB consecutive scans show it alone, provided the
    // keypad was seen empty for DB consecutive scans since the previous acceptance.
    function automatic int model_scan(input logic [11:0] k);
        int cls;
        int acc;
        bit same;
        acc = -1;
        cls = classify(k);
        win.push_back(cls);
        if (win.size() > DB) void'(win.pop_front());
        if (armed) begin
            if (cls >= 0 && win.size() == DB) begin
                same = 1'b1;
                foreach (win[i]) if (win[i] != cls) same = 1'b0;
                if (same) begin
                    acc = cls;
                    armed = 1'b0;
                    none_run = 0;
                end
            end
        end else begin
            none_run = (cls == -1) ? none_run + 1 : 0;
            if (none_run >= DB) armed = 1'b1;
        end
        return acc;
    endfunction

    task automatic model_reset();
        win.delete();
        armed = 1'b1;
        none_run = 0;
    endtask

    task automatic check(input int ci, input int exp_code, input string tag);
        logic [2:0] ec;
        logic [9:0] ek;
        logic       ep, es;
        ec = ~(3'b001 << (ci / SD));
        ek = '0;
        if (exp_code >= 0 && exp_code <= 9) ek[exp_code] = 1'b1;
        ep = (exp_code != 11);
        es = (exp_code != 10);
        if (exp_code >= 0) exp_last = exp_code;
        n_vec++;
        if (bus.cols_n !== ec || bus.keypad !== ek || bus.start_n !== ep ||
            bus.stop_n !== es || bus.last_key !== 4'(exp_last)) begin
            n_bad++;
            $display("FAIL %s clk%0d: got cols=%b key=%b start_n=%b stop_n=%b last=%0d, want cols=%b key=%b start_n=%b stop_n=%b last=%0d",
                     tag, ci, bus.cols_n, bus.keypad, bus.start_n, bus.stop_n, bus.last_key,
                     ec, ek, ep, es, exp_last);
        end
    endtask

    // Entered at the negedge of clock 0 of a scan; leaves at clock 0 of the next scan.
    task automatic run_scan(input logic [11:0] k, input int exp_code, input string tag);
        keys = k;
        for (int i = 1; i < SCAN_CLKS; i++) begin
            @(negedge clock);
            check(i, -1, tag);
        end
        @(negedge clock);
        check(0, exp_code, tag);
    endtask

    task automatic do_reset(input string tag);
        clearn = 1'b0;
        @(negedge clock);
        exp_last = 0;
        model_reset();
        check(0, -1, tag);
        clearn = 1'b1;
    endtask

    initial begin
        vec_t        tbl[$];
        logic [11:0] cur;
        int          p;

        // Directed scenarios: one record per full scan, expected strobe after it.
        tbl.push_back('{12'h000, -1}); tbl.push_back('{12'h000, -1});
        tbl.push_back('{K(5), -1}); tbl.push_back('{K(5), 5});
        tbl.push_back('{K(5), -1}); tbl.push_back('{K(5), -1}); tbl.push_back('{K(5), -1});
        tbl.push_back('{12'h000, -1}); tbl.push_back('{12'h000, -1});
        tbl.push_back('{K(11), -1}); tbl.push_back('{K(11), 11}); tbl.push_back('{K(11), -1});
        tbl.push_back('{12'h000, -1}); tbl.push_back('{12'h000, -1});
        tbl.push_back('{K(10), -1}); tbl.push_back('{K(10), 10});
        tbl.push_back('{12'h000, -1}); tbl.push_back('{12'h000, -1});
        tbl.push_back('{K(7), -1});
        tbl.push_back('{12'h000, -1}); tbl.push_back('{12'h000, -1});
        tbl.push_back('{K(1) | K(2), -1}); tbl.push_back('{K(1) | K(2), -1});
        tbl.push_back('{K(1) | K(2), -1});
        tbl.push_back('{K(2), -1}); tbl.push_back('{K(2), 2});
        tbl.push_back('{12'h000, -1}); tbl.push_back('{12'h000, -1});
        tbl.push_back('{K(3), -1}); tbl.push_back('{K(3), 3});
        tbl.push_back('{K(3) | K(6), -1}); tbl.push_back('{K(3) | K(6), -1});
        tbl.push_back('{K(6), -1}); tbl.push_back('{K(6), -1});
        tbl.push_back('{12'h000, -1}); tbl.push_back('{12'h000, -1});
        tbl.push_back('{K(6), -1}); tbl.push_back('{K(6), 6});
        tbl.push_back('{12'h000, -1}); tbl.push_back('{12'h000, -1});

        keys = '0;
        do_reset("reset");
        foreach (tbl[i]) run_scan(tbl[i].keys, tbl[i].exp_code, "table");

        // Reset while '9' is mid-debounce: no strobe, then a fresh two-scan acceptance.
        run_scan(K(9), -1, "rst9_pre");
        do_reset("rst9_reset");
        run_scan(K(9), -1, "rst9_scan1");
        run_scan(K(9), 9, "rst9_scan2");
        run_scan(12'h000, -1, "rst9_rel");
        run_scan(12'h000, -1, "rst9_rel");

        // Randomised key activity against the reference model, with occasional resets.
        do_reset("rnd_reset");
        cur = '0;
        for (int s = 0; s < 250; s++) begin
            p = $urandom_range(0, 99);
            if (p < 3) begin
                do_reset("rnd_midreset");
            end else if (p < 40) begin
                cur = cur;
            end else if (p < 65) begin
                cur = '0;
            end else if (p < 90) begin
                cur = '0;
                cur[$urandom_range(0, 11)] = 1'b1;
            end else begin
                cur = '0;
                cur[$urandom_range(0, 11)] = 1'b1;
                cur[$urandom_range(0, 11)] = 1'b1;
            end
            run_scan(cur, model_scan(cur), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
